binary_to_gray: RTL and testbench
=================================

// Module: binary_to_gray
// PURPOSE
//   Binary-to-Gray code converter with a registered path for pipelines.
//   - g: purely combinational Binary->Gray of b, for glue logic and counters.
//   - dout: registered output, one cycle of latency, with a valid strobe. It
//     converts either Binary->Gray or Gray->Binary, chosen by mode.
//   - Used at clock-domain-crossing pointer encoders and for test/debug decode.
// PARAMETERS
//   WIDTH     4   code width in bits, legal range >= 2
//   RST_VAL   0   reset value of dout; width WIDTH
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   b          in   WIDTH  binary input to the combinational path
//   g          out  WIDTH  combinational Gray code of b
//   in_valid   in   1      din/mode qualify; sampled on rising clk
//   mode       in   1      0 = Binary->Gray, 1 = Gray->Binary
//   din        in   WIDTH  input to the registered converter
//   dout       out  WIDTH  registered conversion result
//   dout_valid out  1      high 1 cycle after an accepted in_valid
// BEHAVIOUR
//   Combinational path
//   - g[WIDTH-1] = b[WIDTH-1].
//   - g[i] = b[i+1] ^ b[i] for i = WIDTH-2..0.
//   - g is independent of clk and rst; it settles within the same delta.
//   - Equivalent form: g = b ^ (b >> 1).
//   Registered path
//   - Binary->Gray (mode=0): res = din ^ (din >> 1).
//   - Gray->Binary (mode=1): res[WIDTH-1] = din[WIDTH-1], then
//     res[i] = res[i+1] ^ din[i] for i = WIDTH-2..0 (prefix XOR from MSB).
//   - On a rising clk with in_valid=1: dout <= res and dout_valid <= 1.
//     Latency is exactly 1 cycle.
//   - On a rising clk with in_valid=0: dout holds its last value and
//     dout_valid <= 0.
//   - No backpressure. A new input is accepted every cycle, so throughput is
//     1 per clk.
//   - mode is sampled together with din. A mode change between consecutive
//     valid cycles takes effect on the very next result.
//   Reset
//   - rst=1 asynchronously forces dout = RST_VAL and dout_valid = 0,
//     immediately and regardless of clk.
//   - While rst=1, in_valid is ignored.
//   - The first capture occurs on the first rising clk after rst deasserts.
//   - Reset asserted mid-stream discards the in-flight result; no output
//     pulse is produced for it.
//   - g is unaffected by rst.
//   Arithmetic and boundary conditions
//   - Results are WIDTH bits wide. No overflow is possible.
//   - All-zeros maps to all-zeros in both directions.
//   - Binary all-ones 4'b1111 maps to Gray 4'b1000.
//   - Adjacent binary codes, including the wrap 1111->0000, produce Gray
//     codes that differ in exactly one bit.
//   - X or Z on inputs propagates to outputs; no sanitising.
// TESTING
//   1. Sweep b = 0..15 at one step per 1 ns. Check g = b^(b>>1) each step,
//      e.g. 0011->0010, 0100->0110, 1010->1111, 1111->1000.
//   2. Single-bit-change check on g: for every b and b+1 mod 16, including
//      the wrap 15->0, $countones(g_prev ^ g) == 1.
//   3. Registered B->G: mode=0, din=4'b1001, in_valid=1 for one cycle.
//      Next cycle: dout = 4'b1101 with a single-cycle dout_valid pulse.
//   4. Registered G->B: mode=1, din = 4'b1000, then 4'b0110 on consecutive
//      valid cycles. Check dout = 4'b1111, then 4'b0100, with dout_valid
//      high for 2 cycles.
//   5. Assert rst asynchronously between edges while dout_valid=1. Check
//      dout = 0 and dout_valid = 0 immediately. After release with
//      in_valid=0, outputs stay at reset values.
//   6. Round trip: feed each of din = 0..15 through B->G, then feed the
//      result back through G->B. Check dout equals the original din.

Source files
------------

// File: rtl/binary_to_gray_if.sv
// Bundles the combinational gray port and the registered converter handshake.
// master drives the inputs, slave is the converter side.
interface binary_to_gray_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] g;
    logic             in_valid;
    logic             mode;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;

    modport master (
        output b,
        output in_valid,
        output mode,
        output din,
        input  g,
        input  dout,
        input  dout_valid
    );

    modport slave (
        input  b,
        input  in_valid,
        input  mode,
        input  din,
        output g,
        output dout,
        output dout_valid
    );
endinterface

// File: rtl/binary_to_gray.sv
// Binary->Gray on b/g, plus a registered Binary<->Gray converter selected by mode.
// Latency: g combinational; dout/dout_valid one cycle after an accepted in_valid.
// Backpressure: none; one input accepted every clk.
module binary_to_gray #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    binary_to_gray_if.slave  bus
);

    logic [WIDTH-1:0] res;

    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] bv);
        return bv ^ (bv >> 1);
    endfunction

    // Prefix XOR from the MSB down undoes the adjacent-bit XOR of Gray coding.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] gv);
        logic [WIDTH-1:0] r;
        r = '0;
        r[WIDTH-1] = gv[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            r[i] = r[i+1] ^ gv[i];
        end
        return r;
    endfunction

    assign bus.g = bin_to_gray(bus.b);

    always_comb begin
        res = bus.mode ? gray_to_bin(bus.din) : bin_to_gray(bus.din);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dout       <= RST_VAL;
            bus.dout_valid <= 1'b0;
        end else begin
            bus.dout_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.dout <= res;
            end
        end
    end

endmodule

// File: tb/tb_binary_to_gray.sv
// Directed, table-driven checks of binary_to_gray: combinational sweep,
// registered conversions, mode switching, async reset and round trip.
module tb_binary_to_gray;

    localparam int WIDTH = 4;

    typedef struct {
        logic             mode;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    binary_to_gray_if #(.WIDTH(WIDTH)) bus ();

    binary_to_gray #(.WIDTH(WIDTH), .RST_VAL(4'b0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] gray_tab [16];
    vec_t             vecs [8];
    logic [WIDTH-1:0] g_prev;
    logic [WIDTH-1:0] g_first;
    logic [WIDTH-1:0] gcode;

    initial begin
        errors = 0;
        checks = 0;

        gray_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                     4'b0110, 4'b0111, 4'b0101, 4'b0100,
                     4'b1100, 4'b1101, 4'b1111, 4'b1110,
                     4'b1010, 4'b1011, 4'b1001, 4'b1000};

        // Back-to-back vectors with mode flipping every cycle.
        vecs[0] = '{1'b0, 4'b0000, 4'b0000};
        vecs[1] = '{1'b1, 4'b0000, 4'b0000};
        vecs[2] = '{1'b0, 4'b1111, 4'b1000};
        vecs[3] = '{1'b1, 4'b1000, 4'b1111};
        vecs[4] = '{1'b0, 4'b0011, 4'b0010};
        vecs[5] = '{1'b1, 4'b1111, 4'b1010};
        vecs[6] = '{1'b0, 4'b1010, 4'b1111};
        vecs[7] = '{1'b1, 4'b0101, 4'b0110};

        rst          = 1'b1;
        bus.b        = '0;
        bus.in_valid = 1'b0;
        bus.mode     = 1'b0;
        bus.din      = '0;
        #1;
        check("reset_dout", 32'(bus.dout), 32'd0);
        check("reset_valid", 32'(bus.dout_valid), 32'd0);

        // in_valid ignored while in reset; g still live.
        bus.in_valid = 1'b1;
        bus.din      = 4'b0110;
        bus.b        = 4'b1111;
        tick();
        check("rst_ignore_valid", 32'(bus.dout_valid), 32'd0);
        check("rst_ignore_dout", 32'(bus.dout), 32'd0);
        check("g_during_rst", 32'(bus.g), 32'(4'b1000));
        bus.in_valid = 1'b0;
        rst = 1'b0;

        // Combinational sweep and single-bit-change property.
        for (int i = 0; i < 16; i++) begin
            bus.b = 4'(i);
            #1;
            check($sformatf("g_sweep_%0d", i), 32'(bus.g), 32'(gray_tab[i]));
            if (i == 0) g_first = bus.g;
            else check($sformatf("g_onebit_%0d", i), $countones(g_prev ^ bus.g), 32'd1);
            g_prev = bus.g;
        end
        check("g_onebit_wrap", $countones(g_prev ^ g_first), 32'd1);

        // Single registered B->G pulse.
        @(negedge clk);
        bus.mode     = 1'b0;
        bus.din      = 4'b1001;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("b2g_dout", 32'(bus.dout), 32'(4'b1101));
        check("b2g_valid", 32'(bus.dout_valid), 32'd1);
        tick();
        check("b2g_valid_drop", 32'(bus.dout_valid), 32'd0);
        check("b2g_hold", 32'(bus.dout), 32'(4'b1101));

        // Two consecutive G->B.
        bus.mode     = 1'b1;
        bus.din      = 4'b1000;
        bus.in_valid = 1'b1;
        tick();
        check("g2b_dout0", 32'(bus.dout), 32'(4'b1111));
        check("g2b_valid0", 32'(bus.dout_valid), 32'd1);
        bus.din = 4'b0110;
        tick();
        bus.in_valid = 1'b0;
        check("g2b_dout1", 32'(bus.dout), 32'(4'b0100));
        check("g2b_valid1", 32'(bus.dout_valid), 32'd1);
        tick();
        check("g2b_valid_drop", 32'(bus.dout_valid), 32'd0);

        // Table-driven stream, one vector per cycle.
        for (int i = 0; i < 8; i++) begin
            bus.mode     = vecs[i].mode;
            bus.din      = vecs[i].din;
            bus.in_valid = 1'b1;
            tick();
            check($sformatf("vec_%0d_dout", i), 32'(bus.dout), 32'(vecs[i].exp));
            check($sformatf("vec_%0d_valid", i), 32'(bus.dout_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        check("stream_end_valid", 32'(bus.dout_valid), 32'd0);

        // Async reset between edges while dout_valid is high, with input in flight.
        bus.mode     = 1'b0;
        bus.din      = 4'b0110;
        bus.in_valid = 1'b1;
        tick();
        check("pre_rst_valid", 32'(bus.dout_valid), 32'd1);
        check("pre_rst_dout", 32'(bus.dout), 32'(4'b0101));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_dout", 32'(bus.dout), 32'd0);
        check("async_rst_valid", 32'(bus.dout_valid), 32'd0);
        tick();
        check("rst_hold_valid", 32'(bus.dout_valid), 32'd0);
        check("rst_hold_dout", 32'(bus.dout), 32'd0);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("post_rst_dout", 32'(bus.dout), 32'd0);
        check("post_rst_valid", 32'(bus.dout_valid), 32'd0);
        tick();
        check("post_rst_dout2", 32'(bus.dout), 32'd0);
        check("post_rst_valid2", 32'(bus.dout_valid), 32'd0);

        // Round trip B->G then G->B for every code.
        for (int d = 0; d < 16; d++) begin
            bus.mode     = 1'b0;
            bus.din      = 4'(d);
            bus.in_valid = 1'b1;
            tick();
            gcode = bus.dout;
            check($sformatf("rt_b2g_%0d", d), 32'(gcode), 32'(gray_tab[d]));
            bus.mode = 1'b1;
            bus.din  = gcode;
            tick();
            check($sformatf("rt_g2b_%0d", d), 32'(bus.dout), 32'(d));
        end
        bus.in_valid = 1'b0;
        tick();
        check("final_valid", 32'(bus.dout_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
